// File: rtl/vs_sync_ram_pkg.sv
// Shared types and constants for the byte-enable RAM with clear engine.
package vs_sync_ram_pkg;

   typedef enum logic [0:0] {
      RAM_IDLE  = 1'b0,
      RAM_CLEAR = 1'b1
   } vs_ram_state_t;

   localparam int RDW_OLD_DATA = 0;
   localparam int RDW_NEW_DATA = 1;

endpackage

// File: rtl/vs_ram_clear_sequencer.sv
// Clear engine: walks every address once after reset or clear_req, holding busy
// until the last word has been zeroed.
module vs_ram_clear_sequencer
   import vs_sync_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear_req,
   output logic                  busy,
   output logic                  clear_we,
   output logic [ADDR_WIDTH-1:0] clear_addr
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   vs_ram_state_t         state_r;
   vs_ram_state_t         state_s;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [ADDR_WIDTH-1:0] addr_s;
   logic                  busy_r;

   // State, address counter and busy flag registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= RAM_CLEAR;
         addr_r  <= ADDR_ZERO;
         busy_r  <= 1'b1;
      end else begin
         state_r <= state_s;
         addr_r  <= addr_s;
         busy_r  <= (state_s == RAM_CLEAR);
      end
   end

   // Next-state logic; clear_req is only honoured from idle.
   always_comb begin
      state_s = state_r;
      addr_s  = addr_r;
      case (state_r)
         RAM_IDLE: begin
            if (clear_req) begin
               state_s = RAM_CLEAR;
               addr_s  = ADDR_ZERO;
            end else begin
               state_s = RAM_IDLE;
               addr_s  = addr_r;
            end
         end
         RAM_CLEAR: begin
            addr_s = addr_r + ADDR_ONE;
            if (addr_r == ADDR_LAST) begin
               state_s = RAM_IDLE;
            end else begin
               state_s = RAM_CLEAR;
            end
         end
         default: begin
            state_s = RAM_CLEAR;
            addr_s  = ADDR_ZERO;
         end
      endcase
   end

   assign busy       = busy_r;
   assign clear_we   = (state_r == RAM_CLEAR);
   assign clear_addr = addr_r;

endmodule

// File: rtl/vs_sync_ram_byte_clear.sv
// Simple dual-port synchronous RAM with byte lanes, read-during-write policy and
// self-clear. Define VS_SYNC_RAM_OUT_REG_EN for an extra output register stage.
module vs_sync_ram_byte_clear
   import vs_sync_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int BYTE_WIDTH = 8,
   parameter int RDW_MODE   = RDW_OLD_DATA
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           clear_req,
   output logic                           busy,
   input  logic                           write_enable,
   input  logic [ADDR_WIDTH-1:0]          write_addr,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] write_byte_en,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic                           read_enable,
   input  logic [ADDR_WIDTH-1:0]          read_addr,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic                           out_valid
);

   localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH     = 2 ** ADDR_WIDTH;

   function automatic logic [DATA_WIDTH-1:0] merge_lanes(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [NUM_BYTES-1:0]  lane_en
   );
      logic [DATA_WIDTH-1:0] word_v;
      word_v = old_word;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (lane_en[i]) begin
            word_v[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
         end else begin
            word_v[i*BYTE_WIDTH +: BYTE_WIDTH] = old_word[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
      return word_v;
   endfunction

   logic                  busy_s;
   logic                  clear_we_s;
   logic [ADDR_WIDTH-1:0] clear_addr_s;

   logic                  user_we_s;
   logic                  rd_accept_s;
   logic                  mem_we_s;
   logic [ADDR_WIDTH-1:0] mem_addr_s;
   logic [NUM_BYTES-1:0]  mem_be_s;
   logic [DATA_WIDTH-1:0] mem_wdata_s;
   logic [DATA_WIDTH-1:0] rd_word_s;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DATA_WIDTH-1:0] out_data_r;
   logic                  out_valid_r;

   vs_ram_clear_sequencer #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .clock      (clock),
      .reset      (reset),
      .clear_req  (clear_req),
      .busy       (busy_s),
      .clear_we   (clear_we_s),
      .clear_addr (clear_addr_s)
   );

   assign user_we_s   = write_enable & ~busy_s;
   assign rd_accept_s = read_enable & ~busy_s;

   // Write-port mux: the clear engine owns the port while it runs.
   always_comb begin
      mem_we_s    = 1'b0;
      mem_addr_s  = write_addr;
      mem_be_s    = write_byte_en;
      mem_wdata_s = in_data;
      if (clear_we_s) begin
         mem_we_s    = 1'b1;
         mem_addr_s  = clear_addr_s;
         mem_be_s    = {NUM_BYTES{1'b1}};
         mem_wdata_s = {DATA_WIDTH{1'b0}};
      end else begin
         mem_we_s    = user_we_s;
         mem_addr_s  = write_addr;
         mem_be_s    = write_byte_en;
         mem_wdata_s = in_data;
      end
   end

   // Storage array with per-lane write enables.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (mem_we_s && mem_be_s[i]) begin
            mem_r[mem_addr_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata_s[i*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // Read word selection, including same-address forwarding in new-data mode.
   always_comb begin
      rd_word_s = mem_r[read_addr];
      if ((RDW_MODE == RDW_NEW_DATA) && user_we_s && (write_addr == read_addr)) begin
         rd_word_s = merge_lanes(mem_r[read_addr], in_data, write_byte_en);
      end else begin
         rd_word_s = mem_r[read_addr];
      end
   end

   // First output stage: data holds when no read is accepted.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_data_r  <= {DATA_WIDTH{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= rd_accept_s;
         if (rd_accept_s) begin
            out_data_r <= rd_word_s;
         end else begin
            out_data_r <= out_data_r;
         end
      end
   end

`ifdef VS_SYNC_RAM_OUT_REG_EN
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  out_valid_q;

   // Optional second output stage, keeps data aligned with the delayed valid.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_data_q  <= {DATA_WIDTH{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_r;
         if (out_valid_r) begin
            out_data_q <= out_data_r;
         end else begin
            out_data_q <= out_data_q;
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
`else
   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
`endif

   assign busy = busy_s;

endmodule

// File: tb/tb_vs_sync_ram_byte_clear.sv
// Bench for vs_sync_ram_byte_clear: old-data and new-data instances share stimulus,
// a behavioural model feeds expected read words into per-instance queues.
module tb_vs_sync_ram_byte_clear;

`ifdef VS_SYNC_RAM_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        clear_req;
   logic        write_enable;
   logic [3:0]  write_addr;
   logic [3:0]  write_byte_en;
   logic [31:0] in_data;
   logic        read_enable;
   logic [3:0]  read_addr;
   logic        busy0, busy1;
   logic [31:0] out_data0, out_data1;
   logic        out_valid0, out_valid1;

   int total = 0;
   int bad   = 0;

   logic [31:0] model_mem [DEPTH];
   int          m_busy = 0;
   logic        pv = 1'b0;
   logic [31:0] exp_d0 = 32'h0;
   logic [31:0] exp_d1 = 32'h0;
   logic [31:0] q0 [$];
   logic [31:0] q1 [$];

   always #5 clock = ~clock;

   vs_sync_ram_byte_clear #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RDW_MODE(0)) dut_old (
      .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busy0),
      .write_enable(write_enable), .write_addr(write_addr), .write_byte_en(write_byte_en),
      .in_data(in_data), .read_enable(read_enable), .read_addr(read_addr),
      .out_data(out_data0), .out_valid(out_valid0)
   );

   vs_sync_ram_byte_clear #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RDW_MODE(1)) dut_new (
      .clock(clock), .reset(reset), .clear_req(clear_req), .busy(busy1),
      .write_enable(write_enable), .write_addr(write_addr), .write_byte_en(write_byte_en),
      .in_data(in_data), .read_enable(read_enable), .read_addr(read_addr),
      .out_data(out_data1), .out_valid(out_valid1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: update the model from the driven inputs, then compare after the edge.
   task automatic step();
      logic        racc, wacc, out_v;
      logic [31:0] old_w, new_w;
      racc  = read_enable && (m_busy == 0) && !reset;
      wacc  = write_enable && (m_busy == 0) && !reset;
      out_v = 1'b0;
      if (racc) begin
         old_w = model_mem[read_addr];
         new_w = old_w;
         if (wacc && (write_addr == read_addr)) begin
            for (int i = 0; i < 4; i++)
               if (write_byte_en[i]) new_w[i*8 +: 8] = in_data[i*8 +: 8];
         end
         q0.push_back(old_w);
         q1.push_back(new_w);
      end
      if (wacc) begin
         for (int i = 0; i < 4; i++)
            if (write_byte_en[i]) model_mem[write_addr][i*8 +: 8] = in_data[i*8 +: 8];
      end
      if (reset) begin
         m_busy = DEPTH;
         for (int a = 0; a < DEPTH; a++) model_mem[a] = 32'h0;
         q0.delete();
         q1.delete();
         pv     = 1'b0;
         exp_d0 = 32'h0;
         exp_d1 = 32'h0;
      end else begin
         if (m_busy > 0) begin
            m_busy--;
         end else if (clear_req) begin
            m_busy = DEPTH;
            for (int a = 0; a < DEPTH; a++) model_mem[a] = 32'h0;
         end
         if (LAT == 2) begin
            out_v = pv;
            pv    = racc;
         end else begin
            out_v = racc;
         end
      end
      @(posedge clock);
      #1;
      if (out_v && q0.size() > 0) begin
         exp_d0 = q0.pop_front();
         exp_d1 = q1.pop_front();
      end
      chk("busy_old",  {31'h0, busy0},      {31'h0, (m_busy != 0)});
      chk("busy_new",  {31'h0, busy1},      {31'h0, (m_busy != 0)});
      chk("valid_old", {31'h0, out_valid0}, {31'h0, out_v});
      chk("valid_new", {31'h0, out_valid1}, {31'h0, out_v});
      chk("data_old",  out_data0, exp_d0);
      chk("data_new",  out_data1, exp_d1);
   endtask

   task automatic cyc(input logic we, input logic [3:0] wa, input logic [31:0] d,
                      input logic [3:0] be, input logic re, input logic [3:0] ra);
      write_enable  = we;
      write_addr    = wa;
      in_data       = d;
      write_byte_en = be;
      read_enable   = re;
      read_addr     = ra;
      step();
   endtask

   task automatic nop(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
   endtask

   // Steps until busy drops, optionally hammering the ports; checks the clear length.
   task automatic clear_run(input string tag, input logic noise);
      int n;
      n = 0;
      do begin
         if (noise) begin
            write_enable  = 1'b1;
            write_addr    = 4'($urandom_range(15, 0));
            in_data       = $urandom;
            write_byte_en = 4'hF;
            read_enable   = 1'b1;
            read_addr     = 4'($urandom_range(15, 0));
            clear_req     = (n == 5);
         end
         step();
         n++;
      end while (busy0 === 1'b1 && n < 64);
      clear_req    = 1'b0;
      write_enable = 1'b0;
      read_enable  = 1'b0;
      chk(tag, n, 32'd16);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      clear_req = 1'b0;
      write_enable = 1'b0; write_addr = 4'h0; write_byte_en = 4'h0; in_data = 32'h0;
      read_enable = 1'b0; read_addr = 4'h0;
      for (int a = 0; a < DEPTH; a++) model_mem[a] = 32'h0;

      step();
      step();
      reset = 1'b0;
      clear_run("reset_clear_len", 1'b0);

      for (int a = 0; a < DEPTH; a++) cyc(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
      nop(2);

      cyc(1'b1, 4'h3, 32'hDEADBEEF, 4'hF, 1'b0, 4'h0);
      cyc(1'b1, 4'h3, 32'h00000011, 4'b0001, 1'b0, 4'h0);
      cyc(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h3);
      nop(2);

      cyc(1'b1, 4'h5, 32'h11111111, 4'hF, 1'b0, 4'h0);
      cyc(1'b1, 4'h5, 32'h22222222, 4'hF, 1'b1, 4'h5);
      cyc(1'b1, 4'h5, 32'h11111111, 4'hF, 1'b0, 4'h0);
      cyc(1'b1, 4'h5, 32'h22222222, 4'b0011, 1'b1, 4'h5);
      cyc(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h5);
      nop(2);

      cyc(1'b1, 4'h6, 32'hCAFEF00D, 4'hF, 1'b0, 4'h0);
      cyc(1'b1, 4'h6, 32'h12345678, 4'h0, 1'b1, 4'h6);
      cyc(1'b1, 4'h7, 32'hA5A5A5A5, 4'hF, 1'b1, 4'h8);
      cyc(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'h7);
      nop(2);

      for (int a = 0; a < DEPTH; a++) cyc(1'b1, 4'(a), 32'hBEEF0000 | a, 4'hF, 1'b0, 4'h0);
      clear_req = 1'b1;
      cyc(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
      clear_req = 1'b0;
      clear_run("clear_req_len", 1'b1);
      for (int a = 0; a < DEPTH; a++) cyc(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
      nop(2);

      for (int a = 0; a < 4; a++) cyc(1'b1, 4'(a), 32'h0F0F0000 + a, 4'hF, 1'b0, 4'h0);
      clear_req = 1'b1;
      cyc(1'b0, 4'h0, 32'h0, 4'h0, 1'b0, 4'h0);
      clear_req = 1'b0;
      for (int k = 0; k < 7; k++) cyc(1'b1, 4'(k), 32'h5555AAAA, 4'hF, 1'b1, 4'(k));
      reset = 1'b1;
      step();
      reset = 1'b0;
      read_enable = 1'b1;
      read_addr   = 4'h2;
      clear_run("reset_mid_clear_len", 1'b0);

      for (int a = 0; a < 4; a++) cyc(1'b1, 4'(a), 32'h70000000 + (a << 8), 4'hF, 1'b0, 4'h0);
      for (int a = 0; a < 4; a++) cyc(1'b0, 4'h0, 32'h0, 4'h0, 1'b1, 4'(a));
      nop(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
